// File: rtl/wave_meas_pkg.sv
// Shared types and defaults for the waveform period meter.
// The threshold helpers clamp the hysteresis band to the 8-bit sample range.
package wave_meas_pkg;

  typedef enum logic [0:0] {
    SEEK  = 1'b0,
    TRACK = 1'b1
  } meas_state_e;

  localparam int HYST_DEF     = 8;
  localparam int MIDSCALE_DEF = 128;
  localparam int CNT_W_DEF    = 16;

  function automatic logic [8:0] th_hi_f(input int mid, input int hyst);
    int sum_v;
    sum_v = mid + hyst;
    if (sum_v > 32'sd255) begin
      return 9'd255;
    end else begin
      return 9'(sum_v);
    end
  endfunction

  function automatic logic [8:0] th_lo_f(input int mid, input int hyst);
    int dif_v;
    dif_v = mid - hyst;
    if (dif_v < 32'sd0) begin
      return 9'd0;
    end else begin
      return 9'(dif_v);
    end
  endfunction

endpackage

// File: rtl/wave_hyst_cmp.sv
// Hysteresis comparator: tracks the hi flag around midscale and strobes rise
// on the valid sample that sets hi while it was clear.
module wave_hyst_cmp
  import wave_meas_pkg::*;
#(
  parameter int HYST     = HYST_DEF,
  parameter int MIDSCALE = MIDSCALE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sample,
  input  logic       sample_valid,
  output logic       rise
);

  localparam logic [8:0] TH_HI = th_hi_f(MIDSCALE, HYST);
  localparam logic [8:0] TH_LO = th_lo_f(MIDSCALE, HYST);

  logic [8:0] sample_ext_s;
  logic       set_s;
  logic       clr_s;
  logic       hi_r;

  // threshold compares and rise strobe
  always_comb begin
    sample_ext_s = {1'b0, sample};
    set_s        = (sample_ext_s >= TH_HI);
    clr_s        = (sample_ext_s < TH_LO);
    rise         = sample_valid & set_s & ~hi_r;
  end

  // hi flag; reset high so a fresh lock needs a low excursion first
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_r <= 1'b1;
    end else if (sample_valid) begin
      if (set_s) begin
        hi_r <= 1'b1;
      end else if (clr_s) begin
        hi_r <= 1'b0;
      end else begin
        hi_r <= hi_r;
      end
    end else begin
      hi_r <= hi_r;
    end
  end

endmodule

// File: rtl/wave_period_meter.sv
// Measures waveform period and peak-to-peak extremes between successive
// rising hysteresis crossings; flags a timeout when no crossing arrives.
module wave_period_meter
  import wave_meas_pkg::*;
#(
  parameter int HYST     = HYST_DEF,
  parameter int MIDSCALE = MIDSCALE_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk_50MHz,
  input  logic             reset,
  input  logic [7:0]       sample_in,
  input  logic             sample_valid,
  output logic [CNT_W-1:0] period_out,
  output logic [7:0]       peak_max_out,
  output logic [7:0]       peak_min_out,
  output logic             meas_valid,
  output logic             timeout_out
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_MAX - CNT_ONE;

  meas_state_e      state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [7:0]       run_max_r, run_max_s;
  logic [7:0]       run_min_r, run_min_s;
  logic [CNT_W-1:0] period_s;
  logic [7:0]       peak_max_s, peak_min_s;
  logic             meas_valid_s, timeout_s;
  logic [7:0]       max_cand_s, min_cand_s;
  logic             rise_s;

  wave_hyst_cmp #(
    .HYST    (HYST),
    .MIDSCALE(MIDSCALE)
  ) u_hyst (
    .clk         (clk_50MHz),
    .reset       (reset),
    .sample      (sample_in),
    .sample_valid(sample_valid),
    .rise        (rise_s)
  );

  // next-state, counter, running peaks and measurement outputs
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    run_max_s    = run_max_r;
    run_min_s    = run_min_r;
    period_s     = period_out;
    peak_max_s   = peak_max_out;
    peak_min_s   = peak_min_out;
    meas_valid_s = 1'b0;
    timeout_s    = timeout_out;
    max_cand_s   = (sample_in > run_max_r) ? sample_in : run_max_r;
    min_cand_s   = (sample_in < run_min_r) ? sample_in : run_min_r;

    if (sample_valid) begin
      case (state_r)
        SEEK: begin
          if (rise_s) begin
            state_s   = TRACK;
            cnt_s     = CNT_ZERO;
            run_max_s = sample_in;
            run_min_s = sample_in;
          end else begin
            state_s = SEEK;
          end
        end
        TRACK: begin
          if (rise_s) begin
            period_s     = cnt_r + CNT_ONE;
            peak_max_s   = max_cand_s;
            peak_min_s   = min_cand_s;
            meas_valid_s = 1'b1;
            timeout_s    = 1'b0;
            cnt_s        = CNT_ZERO;
            run_max_s    = sample_in;
            run_min_s    = sample_in;
          end else if (cnt_r == CNT_LAST) begin
            // counter would saturate: give up on this reference edge
            timeout_s = 1'b1;
            state_s   = SEEK;
            cnt_s     = CNT_ZERO;
          end else begin
            cnt_s     = cnt_r + CNT_ONE;
            run_max_s = max_cand_s;
            run_min_s = min_cand_s;
          end
        end
        default: begin
          state_s = SEEK;
          cnt_s   = CNT_ZERO;
        end
      endcase
    end else begin
      meas_valid_s = 1'b0;
    end
  end

  // state and output registers
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state_r      <= SEEK;
      cnt_r        <= CNT_ZERO;
      run_max_r    <= 8'd0;
      run_min_r    <= 8'd0;
      period_out   <= CNT_ZERO;
      peak_max_out <= 8'd0;
      peak_min_out <= 8'd0;
      meas_valid   <= 1'b0;
      timeout_out  <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      run_max_r    <= run_max_s;
      run_min_r    <= run_min_s;
      period_out   <= period_s;
      peak_max_out <= peak_max_s;
      peak_min_out <= peak_min_s;
      meas_valid   <= meas_valid_s;
      timeout_out  <= timeout_s;
    end
  end

endmodule

// File: tb/tb_wave_period_meter.sv
// Randomized and directed bench for wave_period_meter against a queue-based
// reference model of the crossing/period rules.
module tb_wave_period_meter;

  localparam int TH_HI   = 136;
  localparam int TH_LO   = 120;
  localparam int TO_SPAN = 65535;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  sample_in = 8'd0;
  logic        sample_valid = 1'b0;
  logic [15:0] period_out;
  logic [7:0]  peak_max_out;
  logic [7:0]  peak_min_out;
  logic        meas_valid;
  logic        timeout_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pulses   = 0;
  int pulse_cyc[$];

  // reference model state
  bit m_hi, m_track, m_mv, m_to;
  int m_period, m_max, m_min;
  int win[$];

  wave_period_meter #(.HYST(8), .MIDSCALE(128), .CNT_W(16)) dut (
    .clk_50MHz   (clk),
    .reset       (reset),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .period_out  (period_out),
    .peak_max_out(peak_max_out),
    .peak_min_out(peak_min_out),
    .meas_valid  (meas_valid),
    .timeout_out (timeout_out)
  );

  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_hi = 1'b1; m_track = 1'b0; m_mv = 1'b0; m_to = 1'b0;
    m_period = 0; m_max = 0; m_min = 0;
    win.delete();
  endfunction

  // a window holds every sample from the reference edge up to the current one
  function automatic void model_step(input int s, input bit v);
    bit rise;
    int mx, mn;
    m_mv = 1'b0;
    if (!v) return;
    rise = !m_hi && (s >= TH_HI);
    if (s >= TH_HI) m_hi = 1'b1;
    else if (s < TH_LO) m_hi = 1'b0;
    if (!m_track) begin
      if (rise) begin
        m_track = 1'b1;
        win.delete();
        win.push_back(s);
      end
    end else if (rise) begin
      mx = s; mn = s;
      foreach (win[i]) begin
        if (win[i] > mx) mx = win[i];
        if (win[i] < mn) mn = win[i];
      end
      m_period = win.size();
      m_max = mx; m_min = mn;
      m_mv = 1'b1; m_to = 1'b0;
      win.delete();
      win.push_back(s);
    end else if (win.size() == TO_SPAN) begin
      m_to = 1'b1;
      m_track = 1'b0;
      win.delete();
    end else begin
      win.push_back(s);
    end
  endfunction

  task automatic compare_all();
    check_eq("meas_valid", meas_valid, m_mv);
    check_eq("timeout_out", timeout_out, m_to);
    check_eq("period_out", period_out, m_period);
    check_eq("peak_max_out", peak_max_out, m_max);
    check_eq("peak_min_out", peak_min_out, m_min);
  endtask

  task automatic step(input int s, input bit v);
    sample_in = s[7:0];
    sample_valid = v;
    @(posedge clk);
    model_step(s, v);
    cyc++;
    #1;
    compare_all();
    if (meas_valid) begin
      pulses++;
      pulse_cyc.push_back(cyc);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sample_valid = 1'b0;
    @(posedge clk);
    model_reset();
    cyc++;
    #1;
    compare_all();
    reset = 1'b0;
  endtask

  // square wave: 5 samples at 0 then 5 at 255; gap inserts an idle cycle per sample
  task automatic square(input int periods, input bit gap);
    for (int p = 0; p < periods; p++) begin
      for (int i = 0; i < 10; i++) begin
        step((i < 5) ? 0 : 255, 1'b1);
        if (gap) step($urandom_range(255), 1'b0);
      end
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();
    check_eq("reset_period", period_out, 0);
    check_eq("reset_meas_valid", meas_valid, 0);

    // basic measurement
    pulses = 0;
    square(4, 1'b0);
    check_eq("sq_pulses", pulses, 3);
    check_eq("sq_period", period_out, 10);
    check_eq("sq_max", peak_max_out, 255);
    check_eq("sq_min", peak_min_out, 0);

    // noise inside the hysteresis band
    pulses = 0;
    for (int i = 0; i < 1000; i++) step((i % 2 == 0) ? 123 : 133, 1'b1);
    check_eq("noise_pulses", pulses, 0);

    // reset mid-period
    do_reset();
    square(2, 1'b0);
    for (int i = 0; i < 3; i++) step(0, 1'b1);
    do_reset();
    check_eq("rst_period", period_out, 0);
    check_eq("rst_max", peak_max_out, 0);
    check_eq("rst_min", peak_min_out, 0);
    check_eq("rst_timeout", timeout_out, 0);
    pulses = 0;
    step(255, 1'b1);
    step(255, 1'b1);
    square(1, 1'b0);
    check_eq("rst_one_edge_pulses", pulses, 0);
    square(1, 1'b0);
    check_eq("rst_two_edge_pulses", pulses, 1);

    // asymmetric triangle
    do_reset();
    for (int p = 0; p < 4; p++)
      for (int k = 0; k < 18; k++)
        step((k <= 9) ? 40 + 20 * k : 220 - 20 * (k - 9), 1'b1);
    check_eq("tri_period", period_out, 18);
    check_eq("tri_max", peak_max_out, 220);
    check_eq("tri_min", peak_min_out, 40);

    // randomized bursts with random valid gaps
    do_reset();
    begin
      bit hi_phase = 1'b0;
      int run_len = 0;
      for (int i = 0; i < 3000; i++) begin
        if (run_len == 0) begin
          hi_phase = ~hi_phase;
          run_len = $urandom_range(12, 1);
        end
        run_len--;
        step(hi_phase ? $urandom_range(255, 100) : $urandom_range(160, 0),
             $urandom_range(3, 0) != 0);
      end
    end

    // gapped input
    do_reset();
    pulse_cyc.delete();
    square(4, 1'b1);
    check_eq("gap_period", period_out, 10);
    check_eq("gap_pulse_count", pulse_cyc.size(), 3);
    if (pulse_cyc.size() >= 2)
      check_eq("gap_spacing", pulse_cyc[pulse_cyc.size()-1] - pulse_cyc[pulse_cyc.size()-2], 20);

    // timeout on DC level, then recovery
    do_reset();
    square(2, 1'b0);
    check_eq("to_lock_period", period_out, 10);
    pulses = 0;
    for (int i = 0; i < 65540; i++) step(200, 1'b1);
    check_eq("to_set", timeout_out, 1);
    check_eq("to_period_held", period_out, 10);
    check_eq("to_no_pulse", pulses, 0);
    square(3, 1'b0);
    check_eq("to_cleared", timeout_out, 0);
    check_eq("to_recover_period", period_out, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wave_period_meter.md
WAVE_PERIOD_METER -- requirements
Module: wave_period_meter

Interface
REQ-001 Parameter HYST, default 8: hysteresis half-width in LSBs around midscale, legal range 0..127.
REQ-002 Parameter MIDSCALE, default 128: unsigned crossing reference level.
REQ-003 Parameter CNT_W, default 16: width of the period counter and of period_out.
REQ-004 clk_50MHz  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 sample_in  input  8  unsigned waveform sample, for example NCO wave output looped back.
REQ-007 sample_valid  input  1  qualifies sample_in; when low, no internal state changes.
REQ-008 period_out  output  CNT_W  last measured period, in valid samples.
REQ-009 peak_max_out  output  8  maximum sample over the last measured period.
REQ-010 peak_min_out  output  8  minimum sample over the last measured period.
REQ-011 meas_valid  output  1  one-cycle pulse when the three measurement outputs update.
REQ-012 timeout_out  output  1  level flag set when no rising event occurs for 2^CNT_W-1 samples.

Function
REQ-013 Thresholds SHALL be computed in 9 bits.
- TH_HI = min(MIDSCALE+HYST, 255).
- TH_LO = max(MIDSCALE-HYST, 0).
REQ-014 The hysteresis flag hi SHALL set on a valid sample >= TH_HI and clear on a valid sample < TH_LO; otherwise it holds.
REQ-015 A rising event SHALL be a valid sample that sets hi while hi was 0.
REQ-016 The FSM SHALL have two states, SEEK (no reference edge) and TRACK (counting).
REQ-017 SEEK -> TRACK on a rising event; no output update on that transition.
REQ-018 On entry to TRACK, and at every rising event in TRACK, the following SHALL happen:
- cnt <= 0.
- run_max and run_min <= current sample.
REQ-019 In TRACK, each valid non-event sample SHALL do the following:
- increment cnt.
- update run_max with max(run_max, sample).
- update run_min with min(run_min, sample).
REQ-020 At a rising event in TRACK, the block SHALL register the following outputs:
- period_out <= cnt+1.
- peak_max_out <= max(run_max, sample).
- peak_min_out <= min(run_min, sample).
- meas_valid <= 1 for exactly one cycle.
- timeout_out <= 0.
REQ-021 Latency: meas_valid SHALL be high in the cycle immediately after the clock edge that accepts the event sample.
REQ-022 If cnt reaches 2^CNT_W-1 in TRACK with no event, the block SHALL do the following on that edge:
- set timeout_out.
- return to SEEK.
- clear cnt.
- leave period_out and both peak outputs unchanged.
- not pulse meas_valid.
REQ-023 Measurement outputs SHALL hold their values between updates.
REQ-024 sample_valid low SHALL freeze cnt, hi, the FSM state and the running peaks.
REQ-025 With HYST=0, TH_HI equals TH_LO equals MIDSCALE, and the rules in REQ-014 apply unchanged.

Reset
REQ-026 While reset is high at a clock edge, the block SHALL return to a known idle state:
- FSM = SEEK, hi = 1, cnt = 0.
- period_out = 0, peak_max_out = 0, peak_min_out = 0.
- meas_valid = 0, timeout_out = 0.
REQ-027 Reset applied mid-period SHALL discard the partial measurement; after reset, two rising events are needed before the next meas_valid.

Structure
REQ-028 A shared package wave_meas_pkg SHALL hold:
- the state enum (SEEK, TRACK).
- the MIDSCALE and CNT_W defaults.
REQ-029 The hysteresis comparator (thresholds, hi flag, rise strobe) SHALL be a sub-module named wave_hyst_cmp.
REQ-030 The FSM, counter, peak tracking and output registers SHALL reside in wave_period_meter.

Verification
REQ-031 Scenario 1 -- basic measurement:
- Stimulus: sample_valid always high; square wave of 5 samples at 0 followed by 5 samples at 255, repeated.
- Response: after the second rising edge, period_out=10, peak_max_out=255, peak_min_out=0, meas_valid high for 1 cycle.
REQ-032 Scenario 2 -- noise rejection:
- Stimulus: HYST=8; samples alternating 123 and 133 for 1000 samples.
- Response: no meas_valid pulse, and hi is not toggled by the noise.
REQ-033 Scenario 3 -- timeout:
- Stimulus: lock as in Scenario 1, then hold DC level 200.
- Response: timeout_out=1 after 65535 valid samples; state = SEEK; period_out stays 10.
- Then restart the square wave: timeout_out clears on the next meas_valid.
REQ-034 Scenario 4 -- gapped input:
- Stimulus: Scenario 1 waveform with sample_valid high every other cycle.
- Response: period_out=10, and meas_valid pulses once per 20 clocks.
REQ-035 Scenario 5 -- reset mid-period:
- Stimulus: assert reset for 1 cycle mid-period.
- Response: all outputs 0; the first meas_valid after reset occurs only after two further rising events.
REQ-036 Scenario 6 -- asymmetric waveform:
- Stimulus: triangle wave stepping 40..220 by 20, period 18 samples.
- Response: period_out=18, peak_max_out=220, peak_min_out=40.
